// File: rtl/scaler_hrlt_norm.sv
// Output normalisation for the horizontal filter result stream.
// Rounds, shifts and clamps each result to a pixel, tags frame/line position and buffers it in a FWFT FIFO.
module scaler_hrlt_norm #(
  parameter int unsigned HRLT_BITWIDTH  = 48,
  parameter int unsigned FRAC_BITS      = 12,
  parameter int unsigned PIXEL_BITWIDTH = 8,
  parameter int unsigned CNT_BITWIDTH   = 12,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned AFULL_MARGIN   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_BITWIDTH-1:0]   cfg_dst_width,
  input  logic [CNT_BITWIDTH-1:0]   cfg_dst_height,
  input  logic                      din_en,
  input  logic [HRLT_BITWIDTH-1:0]  din_hrlt,
  output logic                      din_afull,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [PIXEL_BITWIDTH-1:0] m_tdata,
  output logic                      m_tuser,
  output logic                      m_tlast,
  output logic                      frame_done,
  output logic                      err_overflow
);

  localparam int unsigned SUM_W     = HRLT_BITWIDTH + 1;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW       = AW + 1;
  localparam int unsigned AFW       = FCW + 1;
  localparam int unsigned EW        = PIXEL_BITWIDTH + 3;
  localparam int unsigned CNTW      = CNT_BITWIDTH;
  localparam int unsigned AFULL_LVL = FIFO_DEPTH - AFULL_MARGIN;
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_BITS - 1);

  logic                          s1_valid;
  logic signed [SUM_W-1:0]       s1_sum;
  logic                          s2_valid;
  logic [PIXEL_BITWIDTH-1:0]     s2_pix;
  logic signed [SUM_W-1:0]       q;
  logic [PIXEL_BITWIDTH-1:0]     pix_c;

  // Stage 1: add half an LSB so the later shift rounds half up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= din_en;
      s1_sum   <= $signed({din_hrlt[HRLT_BITWIDTH-1], din_hrlt}) + HALF;
    end
  end

  assign q = s1_sum >>> FRAC_BITS;

  always_comb begin
    pix_c = q[PIXEL_BITWIDTH-1:0];
    if (q[SUM_W-1]) begin
      pix_c = '0;
    end else if (|q[SUM_W-2:PIXEL_BITWIDTH]) begin
      pix_c = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_pix   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_pix   <= pix_c;
    end
  end

  // Frame/line position at the FIFO write side; frame size latched on the first pixel
  logic [CNTW-1:0] x_cnt, y_cnt, w_lat, h_lat;
  logic [CNTW-1:0] cfg_w, cfg_h, eff_w, eff_h;
  logic            frame_start, eol, eof;

  assign frame_start = (x_cnt == '0) && (y_cnt == '0);
  assign cfg_w       = (cfg_dst_width  == '0) ? CNTW'(1) : cfg_dst_width;
  assign cfg_h       = (cfg_dst_height == '0) ? CNTW'(1) : cfg_dst_height;
  assign eff_w       = frame_start ? cfg_w : w_lat;
  assign eff_h       = frame_start ? cfg_h : h_lat;
  assign eol         = (x_cnt == eff_w - CNTW'(1));
  assign eof         = eol && (y_cnt == eff_h - CNTW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
      w_lat <= CNTW'(1);
      h_lat <= CNTW'(1);
    end else if (s2_valid) begin
      if (frame_start) begin
        w_lat <= cfg_w;
        h_lat <= cfg_h;
      end
      if (eol) begin
        x_cnt <= '0;
        y_cnt <= eof ? '0 : y_cnt + CNTW'(1);
      end else begin
        x_cnt <= x_cnt + CNTW'(1);
      end
    end
  end

  // First-word-fall-through FIFO of {eof, sof, eol, pixel}
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [FCW-1:0] count, count_nxt;
  logic [EW-1:0]  head;
  logic           full, rd, wr;

  assign full      = (count == FCW'(FIFO_DEPTH));
  assign rd        = m_tvalid && m_tready;
  assign wr        = s2_valid && (!full || rd);
  assign count_nxt = count + FCW'(wr) - FCW'(rd);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= {eof, frame_start, eol, s2_pix};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      din_afull    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      // Reflects the post-edge fill plus whatever is still in the two pipe stages
      din_afull <= (AFW'(count_nxt) + AFW'(din_en) + AFW'(s1_valid)) >= AFW'(AFULL_LVL);
      if (s2_valid && full && !rd) err_overflow <= 1'b1;
    end
  end

  assign m_tvalid   = (count != '0);
  assign m_tdata    = m_tvalid ? head[PIXEL_BITWIDTH-1:0] : '0;
  assign m_tlast    = m_tvalid && head[PIXEL_BITWIDTH];
  assign m_tuser    = m_tvalid && head[PIXEL_BITWIDTH+1];
  assign frame_done = rd && head[PIXEL_BITWIDTH+2];

endmodule
